// File: rtl/exc_controller.sv
// Exception controller: accepts overflow/undefined-opcode traps,
// redirects fetch, records EPC/Cause, and sequences ERET.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   ovf_e, und_d, eret_d           exception / return requests
//   pc_e, pc_d                     PCs of Execute / Decode instructions
//   flush_d, flush_e, flush_m      pipeline register flushes (comb)
//   pc_sel                         0 seq, 1 vector_pc, 2 epc (comb)
//   vector_pc                      handler entry address
//   epc, cause                     exception PC / Cause registers
//   exc_active                     high in HANDLER or RETURN
//   double_fault                   sticky nested-exception flag
//   exc_count                      saturating accepted-exception count
module exc_controller #(
   parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
   parameter logic [31:0] CAUSE_OVF  = 32'h0000_0030,
   parameter logic [31:0] CAUSE_UND  = 32'h0000_0028
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ovf_e,
   input  logic        und_d,
   input  logic        eret_d,
   input  logic [31:0] pc_e,
   input  logic [31:0] pc_d,
   output logic        flush_d,
   output logic        flush_e,
   output logic        flush_m,
   output logic [1:0]  pc_sel,
   output logic [31:0] vector_pc,
   output logic [31:0] epc,
   output logic [31:0] cause,
   output logic        exc_active,
   output logic        double_fault,
   output logic [7:0]  exc_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HANDLER = 2'd1,
      RETURN  = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_epc;
   logic [31:0] r_cause;
   logic        r_exc_active;
   logic        r_double_fault;
   logic [7:0]  r_exc_count;
   logic        w_exc;

   assign w_exc = ovf_e | und_d;

   // Redirect/flush decode. Forced quiet while reset is held so a
   // pending exception input cannot disturb the pipeline.
   always_comb begin
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_m = 1'b0;
      pc_sel  = 2'd0;
      if (rst_n) begin
         unique case (r_state)
            IDLE: begin
               // Execute instruction is older, so overflow wins
               if (ovf_e) begin
                  flush_d = 1'b1;
                  flush_e = 1'b1;
                  flush_m = 1'b1;
                  pc_sel  = 2'd1;
               end else if (und_d) begin
                  flush_d = 1'b1;
                  flush_e = 1'b1;
                  pc_sel  = 2'd1;
               end
            end
            HANDLER: begin
               if (eret_d) begin
                  flush_d = 1'b1;
                  pc_sel  = 2'd2;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_epc          <= 32'd0;
         r_cause        <= 32'd0;
         r_exc_active   <= 1'b0;
         r_double_fault <= 1'b0;
         r_exc_count    <= 8'd0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_exc) begin
                  r_epc        <= ovf_e ? pc_e : pc_d;
                  r_cause      <= ovf_e ? CAUSE_OVF : CAUSE_UND;
                  r_state      <= HANDLER;
                  r_exc_active <= 1'b1;
                  if (r_exc_count != 8'hFF)
                     r_exc_count <= r_exc_count + 8'd1;
               end
            end
            HANDLER: begin
               if (w_exc)
                  r_double_fault <= 1'b1;
               if (eret_d)
                  r_state <= RETURN;
            end
            RETURN: begin
               if (w_exc)
                  r_double_fault <= 1'b1;
               r_state      <= IDLE;
               r_exc_active <= 1'b0;
            end
            default: begin
               r_state      <= IDLE;
               r_exc_active <= 1'b0;
            end
         endcase
      end
   end

   assign vector_pc    = EXC_VECTOR;
   assign epc          = r_epc;
   assign cause        = r_cause;
   assign exc_active   = r_exc_active;
   assign double_fault = r_double_fault;
   assign exc_count    = r_exc_count;

endmodule

// File: tb/tb_exc_controller.sv
// Directed bench for exc_controller: vector table plus
// reset-in-handler, ERET-with-exception and saturation sequences.
module tb_exc_controller;

   logic        clk;
   logic        rst_n;
   logic        ovf_e;
   logic        und_d;
   logic        eret_d;
   logic [31:0] pc_e;
   logic [31:0] pc_d;
   logic        flush_d;
   logic        flush_e;
   logic        flush_m;
   logic [1:0]  pc_sel;
   logic [31:0] vector_pc;
   logic [31:0] epc;
   logic [31:0] cause;
   logic        exc_active;
   logic        double_fault;
   logic [7:0]  exc_count;

   int errors;
   int checks;

   exc_controller dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ovf_e        (ovf_e),
      .und_d        (und_d),
      .eret_d       (eret_d),
      .pc_e         (pc_e),
      .pc_d         (pc_d),
      .flush_d      (flush_d),
      .flush_e      (flush_e),
      .flush_m      (flush_m),
      .pc_sel       (pc_sel),
      .vector_pc    (vector_pc),
      .epc          (epc),
      .cause        (cause),
      .exc_active   (exc_active),
      .double_fault (double_fault),
      .exc_count    (exc_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ovf;
      logic        und;
      logic        eret;
      logic [31:0] pce;
      logic [31:0] pcd;
      logic        fd;
      logic        fe;
      logic        fm;
      logic [1:0]  sel;
      logic        act;
      logic [31:0] epc;
      logic [31:0] cause;
      logic [7:0]  cnt;
      logic        df;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_comb(input string tag, input logic fd,
                             input logic fe, input logic fm,
                             input logic [1:0] sel);
      check({tag, " flush_d"}, 32'(flush_d), 32'(fd));
      check({tag, " flush_e"}, 32'(flush_e), 32'(fe));
      check({tag, " flush_m"}, 32'(flush_m), 32'(fm));
      check({tag, " pc_sel"}, 32'(pc_sel), 32'(sel));
   endtask

   task automatic clr_in();
      ovf_e  = 1'b0;
      und_d  = 1'b0;
      eret_d = 1'b0;
      pc_e   = 32'd0;
      pc_d   = 32'd0;
   endtask

   // Leaves time at posedge+1 with the block in IDLE
   task automatic do_reset();
      clr_in();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      clr_in();
      rst_n = 1'b0;
      #2;
      check("rst epc", epc, 32'd0);
      check("rst cause", cause, 32'd0);
      check("rst cnt", 32'(exc_count), 32'd0);
      check("rst act", 32'(exc_active), 32'd0);
      check("rst df", 32'(double_fault), 32'd0);
      check("vector_pc", vector_pc, 32'h8000_0180);
      do_reset();

      //          ovf  und  eret pc_e          pc_d
      //          fd   fe   fm   sel   act  epc  cause  cnt  df
      vecs[0]  = '{0, 0, 0, 32'h0, 32'h0,
                   0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 8'd0, 0};
      vecs[1]  = '{0, 0, 1, 32'h0, 32'h0,
                   0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 8'd0, 0};
      vecs[2]  = '{1, 0, 0, 32'h0040_0010, 32'h0,
                   1, 1, 1, 2'd1, 1, 32'h0040_0010, 32'h30, 8'd1, 0};
      vecs[3]  = '{0, 0, 0, 32'h0, 32'h0,
                   0, 0, 0, 2'd0, 1, 32'h0040_0010, 32'h30, 8'd1, 0};
      vecs[4]  = '{1, 0, 0, 32'hDEAD, 32'h0,
                   0, 0, 0, 2'd0, 1, 32'h0040_0010, 32'h30, 8'd1, 1};
      vecs[5]  = '{0, 0, 1, 32'h0, 32'h0,
                   1, 0, 0, 2'd2, 1, 32'h0040_0010, 32'h30, 8'd1, 1};
      vecs[6]  = '{0, 0, 0, 32'h0, 32'h0,
                   0, 0, 0, 2'd0, 0, 32'h0040_0010, 32'h30, 8'd1, 1};
      vecs[7]  = '{0, 1, 0, 32'h0, 32'h0040_0020,
                   1, 1, 0, 2'd1, 1, 32'h0040_0020, 32'h28, 8'd2, 1};
      vecs[8]  = '{0, 0, 1, 32'h0, 32'h0,
                   1, 0, 0, 2'd2, 1, 32'h0040_0020, 32'h28, 8'd2, 1};
      vecs[9]  = '{0, 1, 0, 32'h0, 32'h0BAD,
                   0, 0, 0, 2'd0, 0, 32'h0040_0020, 32'h28, 8'd2, 1};
      vecs[10] = '{1, 1, 0, 32'h100, 32'h104,
                   1, 1, 1, 2'd1, 1, 32'h100, 32'h30, 8'd3, 1};
      vecs[11] = '{1, 0, 1, 32'h200, 32'h0,
                   1, 0, 0, 2'd2, 1, 32'h100, 32'h30, 8'd3, 1};
      vecs[12] = '{0, 0, 0, 32'h0, 32'h0,
                   0, 0, 0, 2'd0, 0, 32'h100, 32'h30, 8'd3, 1};

      for (int i = 0; i < 13; i++) begin
         ovf_e  = vecs[i].ovf;
         und_d  = vecs[i].und;
         eret_d = vecs[i].eret;
         pc_e   = vecs[i].pce;
         pc_d   = vecs[i].pcd;
         #3;
         check_comb($sformatf("v%0d", i), vecs[i].fd, vecs[i].fe,
                    vecs[i].fm, vecs[i].sel);
         @(posedge clk);
         #1;
         check($sformatf("v%0d act", i), 32'(exc_active),
               32'(vecs[i].act));
         check($sformatf("v%0d epc", i), epc, vecs[i].epc);
         check($sformatf("v%0d cause", i), cause, vecs[i].cause);
         check($sformatf("v%0d cnt", i), 32'(exc_count),
               32'(vecs[i].cnt));
         check($sformatf("v%0d df", i), 32'(double_fault),
               32'(vecs[i].df));
      end

      // Reset asserted between edges while in HANDLER
      clr_in();
      ovf_e = 1'b1;
      pc_e  = 32'h0000_0500;
      @(posedge clk);
      #1;
      clr_in();
      check("pre-rst act", 32'(exc_active), 32'd1);
      #2;
      rst_n = 1'b0;
      ovf_e = 1'b1;
      und_d = 1'b1;
      pc_e  = 32'h0000_0600;
      #1;
      check("midrst epc", epc, 32'd0);
      check("midrst cause", cause, 32'd0);
      check("midrst cnt", 32'(exc_count), 32'd0);
      check("midrst act", 32'(exc_active), 32'd0);
      check("midrst df", 32'(double_fault), 32'd0);
      check_comb("midrst", 0, 0, 0, 2'd0);
      #1;
      rst_n = 1'b1;
      #1;
      check_comb("postrst", 1, 1, 1, 2'd1);
      @(posedge clk);
      #1;
      clr_in();
      check("postrst epc", epc, 32'h0000_0600);
      check("postrst cause", cause, 32'h30);
      check("postrst cnt", 32'(exc_count), 32'd1);
      check("postrst act", 32'(exc_active), 32'd1);

      // ERET together with an exception in HANDLER
      eret_d = 1'b1;
      und_d  = 1'b1;
      pc_d   = 32'h0000_0700;
      #3;
      check_comb("eret+und", 1, 0, 0, 2'd2);
      @(posedge clk);
      #1;
      clr_in();
      check("eret+und df", 32'(double_fault), 32'd1);
      check("eret+und epc", epc, 32'h0000_0600);
      check("eret+und cnt", 32'(exc_count), 32'd1);
      check("eret+und act", 32'(exc_active), 32'd1);
      @(posedge clk);
      #1;
      check("eret+und idle", 32'(exc_active), 32'd0);

      // Saturation of the accepted-exception counter
      do_reset();
      for (int i = 0; i < 256; i++) begin
         ovf_e = 1'b1;
         pc_e  = 32'(i);
         @(posedge clk);
         #1;
         ovf_e  = 1'b0;
         eret_d = 1'b1;
         @(posedge clk);
         #1;
         eret_d = 1'b0;
         @(posedge clk);
         #1;
         if (i == 0)
            check("sat cnt1", 32'(exc_count), 32'd1);
         if (i == 254)
            check("sat cnt255", 32'(exc_count), 32'hFF);
      end
      check("sat cnt256", 32'(exc_count), 32'hFF);
      check("sat epc", epc, 32'd255);
      check("sat df", 32'(double_fault), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
